vga_pixel_status_gen: RTL and testbench
=======================================

// Module: vga_pixel_status_gen
// PURPOSE
// - Generates 640x480@60 VGA raster timing (hsync/vsync/video_on) and live pixel coordinates from the system clock.
// - Publishes a packed 32-bit pixel_status word that drives the Avalon PIO input (in_port) of the pixel-status slave directly downstream.
// - Software polls that slave to sync framebuffer updates to vblank and to read the frame count.
// PARAMETERS
// - CLK_DIV   2    system clocks per pixel (50 MHz -> 25 MHz pixel rate); legal >= 1
// - H_ACTIVE 640   visible pixels per line
// - H_FP      16   horizontal front porch (pixels)
// - H_SYNC    96   hsync pulse width (pixels)
// - H_BP      48   horizontal back porch (pixels); H_TOTAL = 800
// - V_ACTIVE 480   visible lines per frame
// - V_FP      10   vertical front porch (lines)
// - V_SYNC     2   vsync pulse width (lines)
// - V_BP      33   vertical back porch (lines); V_TOTAL = 525
// PORTS
// - clk           in   1   system clock
// - reset         in   1   asynchronous reset, active-high
// - enable        in   1   1 = raster runs; 0 = all counters frozen
// - hsync_n       out  1   horizontal sync, active-low
// - vsync_n       out  1   vertical sync, active-low
// - video_on      out  1   1 while (h,v) is inside the active area
// - pixel_x       out 10   current horizontal count, 0..H_TOTAL-1
// - pixel_y       out 10   current vertical count, 0..V_TOTAL-1
// - frame_start   out  1   one-clk pulse when the raster enters (0,0)
// - pixel_status  out 32   {video_on, vblank, ~hsync_n, ~vsync_n, pixel_y, pixel_x, frame_cnt[7:0]}
// BEHAVIOUR
// - One clock domain. reset is asynchronous and active-high.
// - Reset values:
//   - div_cnt, h_cnt, v_cnt and frame_cnt = 0.
//   - hsync_n = vsync_n = 1. video_on = 0, frame_start = 0.
//   - pixel_x = pixel_y = 0, pixel_status = 32'h0.
//   - Reset mid-frame aborts the frame; no frame_start pulse is issued during reset.
// - Pixel tick:
//   - div_cnt counts 0..CLK_DIV-1 and wraps; tick = enable && (div_cnt == CLK_DIV-1).
//   - With CLK_DIV = 1, tick = enable.
// - Counters (advance on tick only):
//   - h_cnt wraps H_TOTAL-1 -> 0.
//   - On that wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
//   - On the v_cnt wrap, frame_cnt increments, 8-bit modulo (255 -> 0).
// - enable = 0:
//   - div_cnt, h_cnt, v_cnt and frame_cnt hold their values.
//   - Outputs keep reflecting the frozen counters; frame_start = 0.
//   - Re-enabling resumes from the frozen position (no restart).
// - Decode (registered from the counters, 1-clk latency, no combinational path to outputs):
//   - video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
//   - vblank = (v_cnt >= V_ACTIVE).
//   - hsync_n = 0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
//   - vsync_n = 0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
//   - pixel_x = h_cnt, pixel_y = v_cnt.
// - frame_start:
//   - Asserted for exactly 1 clk, in the cycle after a tick moves (h,v) from (799,524) to (0,0).
//   - The first frame after reset produces no pulse.
// - pixel_status bit map:
//   - [31] video_on, [30] vblank, [29] hsync active, [28] vsync active.
//   - [27:18] pixel_y, [17:8] pixel_x, [7:0] frame_cnt.
//   - All fields are taken from the same registered snapshot, so the word is always self-consistent.
// - Widths: all counters are 10 bits; parameter totals must be <= 1024 (elaboration check).
// STRUCTURE
// - Shared package vga_timing_pkg holds:
//   - H_/V_ timing constants and derived H_TOTAL, V_TOTAL, sync start/end;
//   - pixel_status field bit positions, shared with the PIO-side software header.
// - One sub-module, vga_axis_counter:
//   - parameterised modulo counter with inc and wrap outputs;
//   - instantiated for the h axis and the v axis.
// - Top level holds the clock divider, the registered decode and status packing.
// TESTING
// - Reset release, enable=1, CLK_DIV=2:
//   - pixel_status = 32'h8000_0000 by clk 2;
//   - pixel_x steps every 2 clks.
// - Full line:
//   - hsync_n low for exactly 192 clks, starting when pixel_x = 656;
//   - line period = 1600 clks.
// - Full frame:
//   - vsync_n low for 2 lines (3200 clks) at pixel_y 490..491;
//   - frame_start pulses once per 840000 clks; frame_cnt +1.
// - enable dropped at (x=100, y=200) for 50 clks:
//   - pixel_status holds {1,0,0,0,200,100,cnt};
//   - resumes at x=100/101 without skipping.
// - 256 frames: frame_cnt wraps 255 -> 0 on the 256th frame_start.
// - Reset asserted at (x=700, y=491):
//   - outputs go to reset values asynchronously;
//   - after release the raster restarts at (0,0) with no frame_start pulse.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and the pixel_status word layout
// (field positions match the software header of the PIO-side reader).
package vga_timing_pkg;

  localparam int CNT_W   = 10;
  localparam int FRAME_W = 8;

  localparam int VGA_CLK_DIV  = 2;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
  localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

  localparam int ST_VIDEO_ON_BIT = 31;
  localparam int ST_VBLANK_BIT   = 30;
  localparam int ST_HSYNC_BIT    = 29;
  localparam int ST_VSYNC_BIT    = 28;
  localparam int ST_Y_LSB        = 18;
  localparam int ST_X_LSB        = 8;
  localparam int ST_FRAME_LSB    = 0;

  typedef struct packed {
    logic               video_on;
    logic               vblank;
    logic               hsync;
    logic               vsync;
    logic [CNT_W-1:0]   y;
    logic [CNT_W-1:0]   x;
    logic [FRAME_W-1:0] frame;
  } pixel_status_t;

  function automatic logic [31:0] pack_status(input pixel_status_t s);
    logic [31:0] w;
    w                            = '0;
    w[ST_VIDEO_ON_BIT]           = s.video_on;
    w[ST_VBLANK_BIT]             = s.vblank;
    w[ST_HSYNC_BIT]              = s.hsync;
    w[ST_VSYNC_BIT]              = s.vsync;
    w[ST_Y_LSB +: CNT_W]         = s.y;
    w[ST_X_LSB +: CNT_W]         = s.x;
    w[ST_FRAME_LSB +: FRAME_W]   = s.frame;
    return w;
  endfunction

endpackage

// File: rtl/vga_pixel_status_gen_axis_counter.sv
// Modulo-MODULUS counter for one raster axis; wrap_o flags the increment
// that takes the count from MODULUS-1 back to 0.
module vga_axis_counter #(
  parameter int MODULUS = 800,
  parameter int W       = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  logic [W-1:0] count_q, count_d;

  assign wrap_o  = inc_i && (count_q == LAST);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_pixel_status_gen.sv
// VGA raster generator: pixel-rate divider, h/v counters, registered sync and
// video decode, and the packed pixel_status word for the downstream PIO.
module vga_pixel_status_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = VGA_CLK_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_start,
  output logic [31:0] pixel_status
);

  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
    $error("vga_pixel_status_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 1) begin : g_div_check
    $error("vga_pixel_status_gen: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               tick;
  logic [CNT_W-1:0]   h_cnt, v_cnt;
  logic               h_wrap, v_wrap;

  // p0: pixel tick and raster counters
  assign tick = enable && (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (enable) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    end
  end

  assign frame_cnt_d = v_wrap ? frame_cnt_q + 1'b1 : frame_cnt_q;

  vga_axis_counter #(.MODULUS(H_TOTAL), .W(CNT_W)) u_h_axis (
    .clk_i   (clk),
    .rst_i   (reset),
    .inc_i   (tick),
    .count_o (h_cnt),
    .wrap_o  (h_wrap)
  );

  vga_axis_counter #(.MODULUS(V_TOTAL), .W(CNT_W)) u_v_axis (
    .clk_i   (clk),
    .rst_i   (reset),
    .inc_i   (h_wrap),
    .count_o (v_cnt),
    .wrap_o  (v_wrap)
  );

  // p1: decode of the current counter snapshot
  logic          video_on_d, vblank_d, hsync_act_d, vsync_act_d;
  pixel_status_t status_fields;
  logic [31:0]   pixel_status_d;

  always_comb begin
    video_on_d     = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    vblank_d       = (int'(v_cnt) >= V_ACTIVE);
    hsync_act_d    = (int'(h_cnt) >= H_SYNC_START) && (int'(h_cnt) < H_SYNC_END);
    vsync_act_d    = (int'(v_cnt) >= V_SYNC_START) && (int'(v_cnt) < V_SYNC_END);
    status_fields  = '{video_on: video_on_d, vblank: vblank_d, hsync: hsync_act_d,
                       vsync: vsync_act_d, y: v_cnt, x: h_cnt, frame: frame_cnt_q};
    pixel_status_d = pack_status(status_fields);
  end

  logic               hsync_n_p1_q, vsync_n_p1_q, video_on_p1_q, frame_start_p1_q;
  logic [CNT_W-1:0]   pixel_x_p1_q, pixel_y_p1_q;
  logic [31:0]        pixel_status_p1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q         <= '0;
      frame_cnt_q       <= '0;
      hsync_n_p1_q      <= 1'b1;
      vsync_n_p1_q      <= 1'b1;
      video_on_p1_q     <= 1'b0;
      frame_start_p1_q  <= 1'b0;
      pixel_x_p1_q      <= '0;
      pixel_y_p1_q      <= '0;
      pixel_status_p1_q <= '0;
    end else begin
      div_cnt_q         <= div_cnt_d;
      frame_cnt_q       <= frame_cnt_d;
      hsync_n_p1_q      <= ~hsync_act_d;
      vsync_n_p1_q      <= ~vsync_act_d;
      video_on_p1_q     <= video_on_d;
      frame_start_p1_q  <= v_wrap;
      pixel_x_p1_q      <= h_cnt;
      pixel_y_p1_q      <= v_cnt;
      pixel_status_p1_q <= pixel_status_d;
    end
  end

  assign hsync_n      = hsync_n_p1_q;
  assign vsync_n      = vsync_n_p1_q;
  assign video_on     = video_on_p1_q;
  assign frame_start  = frame_start_p1_q;
  assign pixel_x      = pixel_x_p1_q;
  assign pixel_y      = pixel_y_p1_q;
  assign pixel_status = pixel_status_p1_q;

endmodule

// File: tb/tb_vga_pixel_status_gen.sv
// Bench for vga_pixel_status_gen on a scaled-down raster (16x8 pixels,
// CLK_DIV=2) so that 256 frames fit in a short run.
module tb_vga_pixel_status_gen;

  localparam int CD  = 2;
  localparam int HA  = 10;
  localparam int HFP = 2;
  localparam int HSW = 3;
  localparam int HBP = 1;
  localparam int VA  = 4;
  localparam int VFP = 1;
  localparam int VSW = 2;
  localparam int VBP = 1;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam logic [55:0] RST_VEC = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 32'd0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        hsync_n, vsync_n, video_on, frame_start;
  logic [9:0]  pixel_x, pixel_y;
  logic [31:0] pixel_status;
  logic [55:0] dut_vec, exp_vec;
  int          en_clks;
  int          checks = 0;
  int          errors = 0;

  vga_pixel_status_gen #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .hsync_n      (hsync_n),
    .vsync_n      (vsync_n),
    .video_on     (video_on),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .frame_start  (frame_start),
    .pixel_status (pixel_status)
  );

  always #5 clk = ~clk;

  assign dut_vec = {hsync_n, vsync_n, video_on, pixel_x, pixel_y, frame_start, pixel_status};

  // Outputs seen for a raster position t ticks after reset.
  function automatic logic [55:0] model_vec(input int t, input logic fs);
    int   h, v, f;
    logic von, vbl, hs, vs;
    h   = t % HT;
    v   = (t / HT) % VT;
    f   = (t / (HT * VT)) % 256;
    von = (h < HA) && (v < VA);
    vbl = (v >= VA);
    hs  = (h >= HA + HFP) && (h < HA + HFP + HSW);
    vs  = (v >= VA + VFP) && (v < VA + VFP + VSW);
    return {~hs, ~vs, von, 10'(h), 10'(v), fs,
            von, vbl, hs, vs, 10'(v), 10'(h), 8'(f)};
  endfunction

  // Ticks elapsed = enabled clocks since reset / CD; a frame starts whenever
  // the tick count reaches a new multiple of the frame size.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      en_clks <= 0;
      exp_vec <= RST_VEC;
    end else begin
      exp_vec <= model_vec(en_clks / CD,
                           enable && (((en_clks + 1) / CD) != (en_clks / CD)) &&
                           ((((en_clks + 1) / CD) % (HT * VT)) == 0));
      if (enable) en_clks <= en_clks + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : main
    fork
      forever begin
        @(negedge clk);
        chk("model", dut_vec, exp_vec);
      end
      begin : stim
        int n;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("status_clk1", pixel_status, 32'h8000_0000);
        chk("x_clk1", pixel_x, 0);
        @(negedge clk);
        chk("status_clk2", pixel_status, 32'h8000_0000);
        chk("x_clk2", pixel_x, 0);
        @(negedge clk); chk("x_clk3", pixel_x, 1);
        @(negedge clk); chk("x_clk4", pixel_x, 1);
        @(negedge clk); chk("x_clk5", pixel_x, 2);

        n = 0;
        while (hsync_n !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        chk("hs_seen", hsync_n, 0);
        chk("hs_start_x", pixel_x, HA + HFP);
        n = 0;
        while (hsync_n === 1'b0 && n < 200) begin @(negedge clk); n++; end
        chk("hs_low_clks", n, 6);
        while (hsync_n !== 1'b0 && n < 400) begin @(negedge clk); n++; end
        chk("line_clks", n, 32);

        n = 0;
        while (vsync_n !== 1'b0 && n < 600) begin @(negedge clk); n++; end
        chk("vs_seen", vsync_n, 0);
        chk("vs_start_y", pixel_y, 5);
        n = 0;
        while (vsync_n === 1'b0 && n < 600) begin @(negedge clk); n++; end
        chk("vs_low_clks", n, 64);

        n = 0;
        while (frame_start !== 1'b1 && n < 600) begin @(negedge clk); n++; end
        chk("fs1_seen", frame_start, 1);
        @(negedge clk);
        chk("status_f1", pixel_status, 32'h8000_0001);
        n = 1;
        while (frame_start !== 1'b1 && n < 600) begin @(negedge clk); n++; end
        chk("frame_clks", n, 256);
        @(negedge clk);
        chk("status_f2", pixel_status, 32'h8000_0002);

        n = 0;
        while (!(pixel_x == 10'd5 && pixel_y == 10'd2) && n < 600) begin @(negedge clk); n++; end
        chk("en_pos", {pixel_y, pixel_x}, {10'd2, 10'd5});
        chk("en_hold_start", pixel_status, 32'h8008_0502);
        enable = 1'b0;
        repeat (50) @(negedge clk);
        chk("en_hold_end", pixel_status, 32'h8008_0502);
        enable = 1'b1;
        @(negedge clk); chk("resume_x0", pixel_x, 5);
        @(negedge clk); chk("resume_x1", pixel_x, 6);

        for (int k = 3; k <= 256; k++) begin
          n = 0;
          do begin @(negedge clk); n++; end while (frame_start !== 1'b1 && n < 600);
          if (frame_start !== 1'b1) begin
            chk("fs_wait", frame_start, 1);
            break;
          end
        end
        chk("fc_pre_wrap", pixel_status[7:0], 8'hFF);
        @(negedge clk);
        chk("fc_wrap", pixel_status, 32'h8000_0000);

        n = 0;
        while (!(pixel_x == 10'd13 && pixel_y == 10'd6) && n < 600) begin @(negedge clk); n++; end
        chk("rst_pos", {pixel_y, pixel_x}, {10'd6, 10'd13});
        #2 reset = 1'b1;
        #1 chk("async_reset", dut_vec, RST_VEC);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_status", pixel_status, 32'h8000_0000);
        chk("rst_fs", frame_start, 0);
        @(negedge clk); chk("rst_x0", pixel_x, 0);
        @(negedge clk); chk("rst_x1", pixel_x, 1);
        repeat (300) @(negedge clk);
      end
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
